// File: rtl/mining_pkg.sv
// rtl/mining_pkg.sv - shared widths, state encoding and byte-order helpers for the mining controller
package mining_pkg;

    localparam int HDR_W   = 608;
    localparam int BLK_W   = 640;
    localparam int DIG_W   = 256;
    localparam int NONCE_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CHECK,
        ST_REPORT,
        ST_DRAIN
    } state_t;

    function automatic logic [DIG_W-1:0] bswap256(input logic [DIG_W-1:0] d);
        logic [DIG_W-1:0] r;
        for (int i = 0; i < DIG_W / 8; i++) begin
            r[8*i +: 8] = d[DIG_W-1-8*i -: 8];
        end
        return r;
    endfunction

    function automatic logic [NONCE_W-1:0] bswap32(input logic [NONCE_W-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// rtl/hash_target_cmp.sv - byte-reverses the hasher digest and tests it against the target
module hash_target_cmp
    import mining_pkg::*;
(
    input  logic [DIG_W-1:0] hash_be,
    input  logic [DIG_W-1:0] target,
    output logic [DIG_W-1:0] hash_le,
    output logic             hit
);

    // The digest arrives in hasher byte order; the target is a plain integer.
    assign hash_le = bswap256(hash_be);
    assign hit     = (hash_le <= target);

endmodule

// File: rtl/mining_ctrl.sv
// rtl/mining_ctrl.sv - sweeps a nonce range through an external hasher and reports the first hit
module mining_ctrl
    import mining_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [HDR_W-1:0]   job_header,
    input  logic [DIG_W-1:0]   job_target,
    input  logic [NONCE_W-1:0] job_nonce_first,
    input  logic [NONCE_W-1:0] job_nonce_last,
    input  logic               abort,
    output logic               sha_start,
    output logic [BLK_W-1:0]   sha_block,
    input  logic [DIG_W-1:0]   sha_hash,
    input  logic               sha_done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_found,
    output logic [NONCE_W-1:0] res_nonce,
    output logic [DIG_W-1:0]   res_hash,
    output logic               busy,
    output logic [NONCE_W-1:0] hash_count
);

    state_t             state, state_n;
    logic [DIG_W-1:0]   target_q;
    logic [DIG_W-1:0]   hash_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [NONCE_W-1:0] last_q;
    logic [NONCE_W-1:0] nonce_inc;
    logic [DIG_W-1:0]   hash_le;
    logic               hit;

    logic accept;
    logic take_hash;
    logic load_res;
    logic advance;

    hash_target_cmp u_cmp (
        .hash_be (hash_q),
        .target  (target_q),
        .hash_le (hash_le),
        .hit     (hit)
    );

    assign nonce_inc = nonce_q + 32'd1;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        take_hash = 1'b0;
        load_res  = 1'b0;
        advance   = 1'b0;
        sha_start = 1'b0;
        job_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    accept  = 1'b1;
                    state_n = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // An abort here suppresses the start so the hasher is never left running.
                if (abort) begin
                    state_n = ST_IDLE;
                end else begin
                    sha_start = 1'b1;
                    state_n   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sha_done) begin
                    take_hash = 1'b1;
                    state_n   = abort ? ST_IDLE : ST_CHECK;
                end else if (abort) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (hit || (nonce_q == last_q)) begin
                    load_res = 1'b1;
                    state_n  = ST_REPORT;
                end else begin
                    advance = 1'b1;
                    state_n = ST_LAUNCH;
                end
            end
            ST_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_n = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (sha_done) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q   <= '0;
            hash_q     <= '0;
            nonce_q    <= '0;
            last_q     <= '0;
            sha_block  <= '0;
            hash_count <= '0;
            res_found  <= 1'b0;
            res_nonce  <= '0;
            res_hash   <= '0;
        end else begin
            if (accept) begin
                target_q   <= job_target;
                last_q     <= job_nonce_last;
                nonce_q    <= job_nonce_first;
                hash_count <= '0;
                sha_block  <= {job_header, bswap32(job_nonce_first)};
            end
            if (take_hash) begin
                hash_q <= sha_hash;
                if (hash_count != '1) begin
                    hash_count <= hash_count + 32'd1;
                end
            end
            if (load_res) begin
                res_found <= hit;
                res_nonce <= nonce_q;
                res_hash  <= hit ? hash_le : '0;
            end
            // The header half of sha_block doubles as the latched job header.
            if (advance) begin
                nonce_q   <= nonce_inc;
                sha_block <= {sha_block[BLK_W-1:NONCE_W], bswap32(nonce_inc)};
            end
        end
    end

endmodule

// File: tb/tb_mining_ctrl.sv
// tb/tb_mining_ctrl.sv - directed self-checking bench for mining_ctrl with a stub hasher
module tb_mining_ctrl;

    localparam int HLAT = 4;
    localparam logic [607:0] GEN_HDR = {32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d};
    localparam logic [255:0] GEN_DIG_BE  = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [255:0] GEN_HASH_LE = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] GEN_TARGET  = {48'h00000000ffff, 208'h0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [607:0] job_header = '0;
    logic [255:0] job_target = '0;
    logic [31:0]  job_nonce_first = '0;
    logic [31:0]  job_nonce_last = '0;
    logic         abort = 1'b0;
    logic         sha_start;
    logic [639:0] sha_block;
    logic [255:0] sha_hash;
    logic         sha_done;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic         res_found;
    logic [31:0]  res_nonce;
    logic [255:0] res_hash;
    logic         busy;
    logic [31:0]  hash_count;

    int checks = 0;
    int errors = 0;

    mining_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_header      (job_header),
        .job_target      (job_target),
        .job_nonce_first (job_nonce_first),
        .job_nonce_last  (job_nonce_last),
        .abort           (abort),
        .sha_start       (sha_start),
        .sha_block       (sha_block),
        .sha_hash        (sha_hash),
        .sha_done        (sha_done),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_found       (res_found),
        .res_nonce       (res_nonce),
        .res_hash        (res_hash),
        .busy            (busy),
        .hash_count      (hash_count)
    );

    always #5 clk = ~clk;

    // Stub hasher: only the genesis header with its real nonce yields a low digest.
    logic [639:0] blk;
    logic         hbusy;
    int           hcnt;
    int           starts = 0;
    int           dones = 0;
    int           unstable = 0;
    int           res_seen = 0;
    logic [31:0]  seen_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hbusy    <= 1'b0;
            hcnt     <= 0;
            sha_done <= 1'b0;
            sha_hash <= '0;
            blk      <= '0;
        end else begin
            sha_done <= 1'b0;
            if (hbusy && (sha_block !== blk)) unstable <= unstable + 1;
            if (res_valid) res_seen <= res_seen + 1;
            if (sha_start) begin
                blk    <= sha_block;
                hbusy  <= 1'b1;
                hcnt   <= HLAT;
                starts <= starts + 1;
                seen_q.push_back({sha_block[7:0], sha_block[15:8], sha_block[23:16], sha_block[31:24]});
            end else if (hbusy) begin
                if (hcnt == 1) begin
                    sha_done <= 1'b1;
                    hbusy    <= 1'b0;
                    dones    <= dones + 1;
                    sha_hash <= (blk[31:0] == 32'h1dac2b7c && blk[639:32] == GEN_HDR) ? GEN_DIG_BE : '1;
                end else begin
                    hcnt <= hcnt - 1;
                end
            end
        end
    end

    task automatic submit(input logic [607:0] h, input logic [255:0] t,
                          input logic [31:0] f, input logic [31:0] l);
        @(negedge clk);
        seen_q.delete();
        job_header      = h;
        job_target      = t;
        job_nonce_first = f;
        job_nonce_last  = l;
        job_valid       = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({job_ready, busy, res_valid, sha_start, res_found} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/valid/start/found=%b expected 10000",
                     {job_ready, busy, res_valid, sha_start, res_found});
        end
        checks++;
        if (hash_count !== 32'd0 || res_nonce !== 32'd0 || res_hash !== 256'd0 || sha_block !== 640'd0) begin
            errors++;
            $display("FAIL reset_data: count=%h nonce=%h hash=%h block_nz=%b expected zeros",
                     hash_count, res_nonce, res_hash, |sha_block);
        end
    endtask

    task automatic test_genesis_hit;
        bit ok;
        submit(GEN_HDR, GEN_TARGET, 32'h7c2bac1a, 32'h7c2bac20);
        wait_res(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL genesis_timeout: res_valid=%b expected 1", res_valid);
        end
        checks++;
        if (res_found !== 1'b1 || res_nonce !== 32'h7c2bac1d) begin
            errors++;
            $display("FAIL genesis_result: found=%b nonce=%h expected 1 7c2bac1d", res_found, res_nonce);
        end
        checks++;
        if (res_hash !== GEN_HASH_LE) begin
            errors++;
            $display("FAIL genesis_hash: got %h expected %h", res_hash, GEN_HASH_LE);
        end
        checks++;
        if (hash_count !== 32'd4) begin
            errors++;
            $display("FAIL genesis_count: got %0d expected 4", hash_count);
        end
        checks++;
        if (seen_q.size() != 4 || seen_q[0] !== 32'h7c2bac1a || seen_q[3] !== 32'h7c2bac1d) begin
            errors++;
            $display("FAIL genesis_order: %0d nonces, first/last %h expected 4 from 7c2bac1a to 7c2bac1d",
                     seen_q.size(), seen_q.size() > 0 ? seen_q[seen_q.size()-1] : 32'h0);
        end
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || hash_count !== 32'd4) begin
            errors++;
            $display("FAIL genesis_idle: ready=%b count=%0d expected 1 4", job_ready, hash_count);
        end
    endtask

    task automatic test_exhausted(input logic [31:0] f, input logic [31:0] l, input int n, input string tag);
        bit ok;
        submit(GEN_HDR, 256'd0, f, l);
        wait_res(ok);
        checks++;
        if (!ok || res_found !== 1'b0 || res_nonce !== l) begin
            errors++;
            $display("FAIL %s_result: ok=%b found=%b nonce=%h expected 1 0 %h", tag, ok, res_found, res_nonce, l);
        end
        checks++;
        if (hash_count !== n) begin
            errors++;
            $display("FAIL %s_count: got %0d expected %0d", tag, hash_count, n);
        end
        checks++;
        if (seen_q.size() != n) begin
            errors++;
            $display("FAIL %s_starts: got %0d expected %0d", tag, seen_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (seen_q[i] !== f + i) begin
                    errors++;
                    $display("FAIL %s_order: slot %0d got %h expected %h", tag, i, seen_q[i], f + i);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int st, dn, rs, us;
        bit ok;
        submit(GEN_HDR, 256'd0, 32'd100, 32'd1000);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        st = starts; dn = dones; rs = res_seen; us = unstable;
        checks++;
        if (busy !== 1'b1 || job_ready !== 1'b0 || dn != 0 && dones == dn && hbusy !== 1'b1) begin
            errors++;
            $display("FAIL abort_drain: busy=%b ready=%b expected 1 0 while hasher runs", busy, job_ready);
        end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (job_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok || dones != dn + 1) begin
            errors++;
            $display("FAIL abort_idle: ready=%b dones_after=%0d expected 1 %0d", job_ready, dones - dn, 1);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (starts != st || res_seen != rs || unstable != us || job_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_quiet: new_starts=%0d results=%0d unstable=%0d ready=%b expected 0 0 0 1",
                     starts - st, res_seen - rs, unstable - us, job_ready);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [31:0]  n0;
        logic [255:0] h0;
        res_ready = 1'b0;
        submit(GEN_HDR, GEN_TARGET, 32'h7c2bac1c, 32'h7c2bac1e);
        wait_res(ok);
        n0 = res_nonce;
        h0 = res_hash;
        checks++;
        if (!ok || n0 !== 32'h7c2bac1d || h0 !== GEN_HASH_LE) begin
            errors++;
            $display("FAIL bp_result: ok=%b nonce=%h expected 1 7c2bac1d", ok, n0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_found !== 1'b1 || res_nonce !== n0 || res_hash !== h0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b found=%b nonce=%h expected 1 1 %h",
                         i, res_valid, res_found, res_nonce, n0);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1 || res_valid !== 1'b0 || hash_count !== 32'd2) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b count=%0d expected 1 0 2", job_ready, res_valid, hash_count);
        end
    endtask

    task automatic test_reset_mid;
        submit(GEN_HDR, 256'd0, 32'd50, 32'd60);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({job_ready, busy, res_valid, sha_start, res_found} !== 5'b10000 ||
            hash_count !== 32'd0 || sha_block !== 640'd0) begin
            errors++;
            $display("FAIL midreset: ready/busy/valid/start/found=%b count=%0d expected 10000 0",
                     {job_ready, busy, res_valid, sha_start, res_found}, hash_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_exhausted(32'd5, 32'd6, 2, "after_reset");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset;
        test_genesis_hit;
        test_exhausted(32'h7c2bac1a, 32'h7c2bac1c, 3, "exhaust");
        test_exhausted(32'hfffffffe, 32'h00000001, 4, "wrap");
        test_exhausted(32'h12345678, 32'h12345678, 1, "single");
        test_abort;
        test_backpressure;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mining_ctrl.md
MINING_CTRL -- requirements
Module: mining_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (clock); rst_n input 1 (reset: asynchronous, active-low).
REQ-002 SHALL have ports: job_valid input 1 (job offered); job_ready output 1 (job accepted when both high).
REQ-003 SHALL have ports: job_header input 608 (header bytes 0..75, byte 0 in [607:600]); job_target input 256 (threshold, unsigned integer).
REQ-004 SHALL have ports: job_nonce_first input 32 and job_nonce_last input 32 (inclusive nonce range).
REQ-005 SHALL have port: abort input 1 (abandon current job).
REQ-006 SHALL have ports: sha_start output 1 (hasher start); sha_block output 640 (80-byte header to hasher).
REQ-007 SHALL have ports: sha_hash input 256 (double-SHA digest); sha_done input 1 (one-cycle completion pulse).
REQ-008 SHALL have ports: res_valid output 1; res_ready input 1; res_found output 1 (1 = hit, 0 = range exhausted).
REQ-009 SHALL have ports: res_nonce output 32; res_hash output 256 (byte-reversed digest of the hit); busy output 1; hash_count output 32.

Function
REQ-010 SHALL implement states IDLE, LAUNCH, WAIT, CHECK, REPORT, DRAIN.
REQ-011 IDLE SHALL assert job_ready; on job_valid, SHALL latch header, target, first and last nonce, set nonce=first, clear hash_count, and go to LAUNCH.
REQ-012 sha_block SHALL equal {header, nonce byte-swapped} (nonce little-endian in bytes 76..79), registered.
REQ-013 sha_block SHALL be held stable from LAUNCH until sha_done.
REQ-014 LAUNCH SHALL pulse sha_start high for exactly one cycle, then go to WAIT.
REQ-015 WAIT SHALL hold until sha_done, register sha_hash, increment hash_count (saturating at 0xFFFFFFFF), and go to CHECK.
REQ-016 CHECK SHALL form hash_le = byte-reverse(sha_hash) and compare it unsigned against target.
REQ-017 CHECK SHALL record a hit when hash_le <= target.
REQ-018 On a hit, CHECK SHALL load res_found=1, res_nonce=nonce, res_hash=hash_le, and go to REPORT.
REQ-019 On a miss with nonce == last, CHECK SHALL load res_found=0, res_nonce=last, and go to REPORT.
REQ-020 On any other miss, CHECK SHALL set nonce = nonce+1 mod 2^32 and go to LAUNCH.
REQ-021 Wrap-around SHALL be supported: first > last iterates through 0xFFFFFFFF to 0; first == last hashes exactly one nonce; first == last+1 covers all 2^32 nonces.
REQ-022 REPORT SHALL hold res_valid and result fields stable until res_ready, then go to IDLE. res_valid && res_ready in the same cycle completes in that cycle.
REQ-023 Per-nonce overhead SHALL be 3 cycles beyond hasher latency (LAUNCH, WAIT->CHECK, CHECK).
REQ-024 abort in LAUNCH or CHECK SHALL go to IDLE, with no sha_start issued afterwards.
REQ-025 abort in WAIT SHALL go to DRAIN; DRAIN SHALL keep sha_block stable, wait for sha_done, and then go to IDLE.
REQ-026 Abort SHALL produce no result.
REQ-027 abort in REPORT SHALL be ignored.
REQ-028 abort in IDLE SHALL be ignored, and job_valid SHALL be accepted normally.
REQ-029 busy SHALL be high in every state except IDLE; job_ready SHALL equal the IDLE state.
REQ-030 hash_count SHALL remain readable after REPORT until the next job is accepted.

Reset
REQ-031 Reset SHALL force state IDLE, sha_start=0, res_valid=0, res_found=0, busy=0, hash_count=0, res_nonce=0, res_hash=0, sha_block=0, and job_ready=1 after release.
REQ-032 Reset asserted mid-job SHALL discard the job; the hasher shares rst_n and restarts with it.

Structure
REQ-033 A shared package mining_pkg SHALL hold the state encoding, header/block/digest width constants and the byte-reverse helper.
REQ-034 The 256-bit byte-reverse plus unsigned compare SHALL be one sub-module, hash_target_cmp (combinational); the hasher SHALL remain external.

Verification
REQ-035 Genesis header prefix, target from bits 0x1d00ffff (0x00000000FFFF followed by zeros), range 0x7C2BAC1A..0x7C2BAC20 -> res_found=1, res_nonce=0x7C2BAC1D, res_hash=0x000000000019d668...0a8ce26f, hash_count=4.
REQ-036 Same prefix, target=0, range 0x7C2BAC1A..0x7C2BAC1C -> res_found=0, res_nonce=0x7C2BAC1C, hash_count=3.
REQ-037 Range 0xFFFFFFFE..0x00000001, target=0 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 presented in sha_block order; hash_count=4; exhausted.
REQ-038 abort two cycles after sha_start -> no further sha_start, sha_block stable until sha_done, then job_ready=1 and res_valid never asserted.
REQ-039 Hit with res_ready held low 10 cycles -> res_valid and fields stable for 10 cycles; IDLE on the first cycle res_ready=1.
REQ-040 rst_n low during WAIT -> all outputs at reset values; a new job runs correctly afterwards.
